// File: rtl/da_pkg.sv
// Shared types and defaults for the distributed-arithmetic FIR controller.
// Holds the FSM state encoding and the bit-index width helper.
package da_pkg;

    localparam int TAPS_D  = 8;
    localparam int DW_D    = 8;
    localparam int ACC_W_D = 32;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        WAIT,
        HOLD
    } state_t;

    function automatic int bidx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/da_fir_ctrl_if.sv
// Sample-in / result-out valid-ready bundle of the DA FIR controller.
// The controller is the slave side; the surrounding system is the master.
interface da_fir_ctrl_if #(
    parameter int DW    = da_pkg::DW_D,
    parameter int ACC_W = da_pkg::ACC_W_D
);

    logic             in_valid;
    logic             in_ready;
    logic [DW-1:0]    in_data;
    logic             out_valid;
    logic             out_ready;
    logic [ACC_W-1:0] out_data;

    modport master (
        output in_valid,
        output in_data,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_data
    );

    modport slave (
        input  in_valid,
        input  in_data,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_data
    );

endinterface

// File: rtl/da_bit_slicer.sv
// Picks bit plane k out of every tap to form the DA LUT address.
// Purely combinational; lut_addr[t] = taps[t][k].
module da_bit_slicer
    import da_pkg::*;
#(
    parameter int TAPS = TAPS_D,
    parameter int DW   = DW_D,
    parameter int KW   = bidx_w(DW)
) (
    input  logic [TAPS-1:0][DW-1:0] taps,
    input  logic [KW-1:0]           k,
    output logic [TAPS-1:0]         lut_addr
);

    always_comb begin
        lut_addr = '0;
        for (int t = 0; t < TAPS; t++) begin
            lut_addr[t] = taps[t][k];
        end
    end

endmodule

// File: rtl/da_fir_ctrl.sv
// Sequencer for the bit-serial DA FIR datapath: delay line, bit-plane
// walk, accumulator strobes and a held result register.
module da_fir_ctrl
    import da_pkg::*;
#(
    parameter int  TAPS   = TAPS_D,
    parameter int  DW     = DW_D,
    parameter int  ACC_W  = ACC_W_D,
    parameter int  DP_LAT = 1,
    localparam int KW     = bidx_w(DW)
) (
    input  logic             clk3,
    input  logic             rst_n,
    da_fir_ctrl_if.slave     io,
    output logic [TAPS-1:0]  lut_addr,
    output logic [KW-1:0]    bit_idx,
    output logic             acc_clr,
    output logic             acc_en,
    output logic             acc_sub,
    input  logic [ACC_W-1:0] dp_sum
);

    localparam logic [KW-1:0] KLAST = KW'(DW - 1);
    localparam logic [1:0]    WLAST = 2'(DP_LAT > 0 ? DP_LAT - 1 : 0);

    state_t                  state;
    state_t                  state_n;
    logic [KW-1:0]           k;
    logic [KW-1:0]           k_n;
    logic [1:0]              wcnt;
    logic [1:0]              wcnt_n;
    logic [TAPS-1:0][DW-1:0] taps;
    logic [TAPS-1:0]         addr_raw;
    logic [ACC_W-1:0]        dout;
    logic                    take;
    logic                    cap;

    da_bit_slicer #(
        .TAPS (TAPS),
        .DW   (DW)
    ) u_slicer (
        .taps     (taps),
        .k        (k),
        .lut_addr (addr_raw)
    );

    // Handshake flags decode the registered state only.
    assign io.in_ready  = (state == IDLE);
    assign io.out_valid = (state == HOLD);
    assign io.out_data  = dout;

    always_comb begin
        state_n  = state;
        k_n      = k;
        wcnt_n   = wcnt;
        take     = 1'b0;
        cap      = 1'b0;
        acc_en   = 1'b0;
        acc_clr  = 1'b0;
        acc_sub  = 1'b0;
        bit_idx  = '0;
        lut_addr = '0;
        unique case (state)
            IDLE: begin
                if (io.in_valid) begin
                    take    = 1'b1;
                    k_n     = '0;
                    state_n = SHIFT;
                end
            end
            SHIFT: begin
                acc_en   = 1'b1;
                bit_idx  = k;
                lut_addr = addr_raw;
                acc_clr  = (k == '0);
                acc_sub  = (k == KLAST);
                if (k == KLAST) begin
                    wcnt_n = '0;
                    if (DP_LAT == 0) begin
                        cap     = 1'b1;
                        state_n = HOLD;
                    end else begin
                        state_n = WAIT;
                    end
                end else begin
                    k_n = k + 1'b1;
                end
            end
            WAIT: begin
                if (wcnt == WLAST) begin
                    cap     = 1'b1;
                    state_n = HOLD;
                end else begin
                    wcnt_n = wcnt + 1'b1;
                end
            end
            HOLD: begin
                if (io.out_ready) begin
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk3 or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            k     <= '0;
            wcnt  <= '0;
            taps  <= '0;
            dout  <= '0;
        end else begin
            state <= state_n;
            k     <= k_n;
            wcnt  <= wcnt_n;
            if (take) begin
                taps <= {taps[TAPS-2:0], io.in_data};
            end
            if (cap) begin
                dout <= dp_sum;
            end
        end
    end

endmodule

// File: tb/tb_da_fir_ctrl.sv
// Bench for da_fir_ctrl: instances with DP_LAT 1, 0 and 3, a behavioural
// DA accumulator for instance 0 and a plain FIR reference model.
module tb_da_fir_ctrl;
    import da_pkg::*;

    localparam int TAPS  = 8;
    localparam int DW    = 8;
    localparam int ACC_W = 32;
    localparam int NI    = 3;
    localparam int NS    = 20;

    logic             clk3 = 1'b0;
    logic             rst_n;
    logic             iv   [NI];
    logic [DW-1:0]    idat [NI];
    logic             ordy [NI];
    logic [ACC_W-1:0] dsv  [NI];
    logic [ACC_W-1:0] ds   [NI];
    logic             ir   [NI];
    logic             ov   [NI];
    logic [ACC_W-1:0] od   [NI];
    logic [TAPS-1:0]  la   [NI];
    logic [2:0]       bi   [NI];
    logic             ac   [NI];
    logic             ae   [NI];
    logic             asb  [NI];

    logic               use_model;
    logic signed [31:0] acc;
    logic signed [7:0]  coef [TAPS];
    int                 xs   [NS];
    int                 n_cmp = 0;
    int                 n_bad = 0;

    always #5 clk3 = ~clk3;

    for (genvar g = 0; g < NI; g++) begin : gi
        localparam int L = (g == 0) ? 1 : ((g == 1) ? 0 : 3);
        da_fir_ctrl_if #(.DW(DW), .ACC_W(ACC_W)) bus ();
        assign bus.in_valid  = iv[g];
        assign bus.in_data   = idat[g];
        assign bus.out_ready = ordy[g];
        assign ir[g]         = bus.in_ready;
        assign ov[g]         = bus.out_valid;
        assign od[g]         = bus.out_data;
        assign ds[g] = (g == 0 && use_model) ? acc : dsv[g];
        da_fir_ctrl #(
            .TAPS(TAPS), .DW(DW), .ACC_W(ACC_W), .DP_LAT(L)
        ) u_dut (
            .clk3     (clk3),
            .rst_n    (rst_n),
            .io       (bus),
            .lut_addr (la[g]),
            .bit_idx  (bi[g]),
            .acc_clr  (ac[g]),
            .acc_en   (ae[g]),
            .acc_sub  (asb[g]),
            .dp_sum   (ds[g])
        );
    end

    function automatic int lat_of(input int i);
        return (i == 0) ? 1 : ((i == 1) ? 0 : 3);
    endfunction

    function automatic int lut_word(input logic [TAPS-1:0] a);
        int s = 0;
        for (int t = 0; t < TAPS; t++)
            if (a[t]) s += int'(coef[t]);
        return s;
    endfunction

    function automatic int ref_y(input int n);
        int s = 0;
        for (int t = 0; t < TAPS; t++)
            if (n - t >= 0) s += int'(coef[t]) * xs[n-t];
        return s;
    endfunction

    // Behavioural datapath: shift-add of LUT words, sign plane subtracted.
    always @(posedge clk3) begin
        if (ae[0] === 1'b1)
            acc <= (ac[0] ? 32'sd0 : acc)
                 + (asb[0] ? -(lut_word(la[0]) <<< bi[0])
                           :  (lut_word(la[0]) <<< bi[0]));
    end

    task automatic tick;
        @(negedge clk3);
    endtask

    task automatic wait_ready(input int i, output bit ok);
        int n = 0;
        while (ir[i] !== 1'b1 && n < 100) begin
            tick;
            n++;
        end
        ok = (ir[i] === 1'b1);
    endtask

    task automatic test_reset;
        logic [15:0] got;
        rst_n = 1'b0;
        tick;
        for (int i = 0; i < NI; i++) begin
            got = {ir[i], ov[i], la[i], bi[i], ac[i], ae[i], asb[i]};
            n_cmp++;
            if (got !== {1'b1, 15'd0}) begin
                n_bad++;
                $display("FAIL reset_ctrl[%0d] got %h want 8000", i, got);
            end
            n_cmp++;
            if (od[i] !== '0) begin
                n_bad++;
                $display("FAIL reset_out[%0d] got %h want 0", i, od[i]);
            end
        end
        rst_n = 1'b1;
        tick;
    endtask

    task automatic test_single;
        int c;
        int k;
        bit ok;
        logic [7:0] e;
        logic [5:0] gc;
        ordy[0] = 1'b1;
        wait_ready(0, ok);
        n_cmp++;
        if (ok !== 1'b1) begin
            n_bad++;
            $display("FAIL single_ready got %0b want 1", ok);
        end
        iv[0] = 1'b1;
        idat[0] = 8'h81;
        tick;
        iv[0] = 1'b0;
        c = 1;
        while (ov[0] !== 1'b1 && c < 40) begin
            if (c <= DW) begin
                k = c - 1;
                e = (k == 0 || k == DW - 1) ? 8'h01 : 8'h00;
                n_cmp++;
                if (la[0] !== e) begin
                    n_bad++;
                    $display("FAIL single_addr k=%0d got %h want %h", k, la[0], e);
                end
                gc = {ae[0], ac[0], asb[0], bi[0]};
                n_cmp++;
                if (gc !== {1'b1, k == 0, k == DW - 1, 3'(k)}) begin
                    n_bad++;
                    $display("FAIL single_ctl k=%0d got %b", k, gc);
                end
            end
            tick;
            c++;
        end
        n_cmp++;
        if (c !== DW + 1 + 1) begin
            n_bad++;
            $display("FAIL single_latency got %0d want %0d", c, DW + 2);
        end
        tick;
    endtask

    task automatic test_delay_line;
        bit ok;
        rst_n = 1'b0;
        tick;
        rst_n = 1'b1;
        ordy[0] = 1'b1;
        for (int s = 1; s <= 9; s++) begin
            wait_ready(0, ok);
            n_cmp++;
            if (ok !== 1'b1) begin
                n_bad++;
                $display("FAIL delay_ready s=%0d got 0 want 1", s);
            end
            iv[0] = 1'b1;
            idat[0] = 8'(s);
            tick;
            iv[0] = 1'b0;
            if (s == 9) begin
                n_cmp++;
                if (la[0] !== 8'b0101_0101) begin
                    n_bad++;
                    $display("FAIL delay_k0 got %b want 01010101", la[0]);
                end
                repeat (3) tick;
                n_cmp++;
                if (la[0] !== 8'b0000_0011) begin
                    n_bad++;
                    $display("FAIL delay_k3 got %b want 00000011", la[0]);
                end
            end
        end
        wait_ready(0, ok);
    endtask

    task automatic test_backpressure;
        bit ok;
        int n;
        logic [ACC_W-1:0] v;
        ordy[0] = 1'b0;
        wait_ready(0, ok);
        v = 32'h1234_5678 ^ $urandom;
        dsv[0] = v;
        iv[0] = 1'b1;
        idat[0] = 8'h5A;
        tick;
        iv[0] = 1'b0;
        n = 0;
        while (ov[0] !== 1'b1 && n < 40) begin
            tick;
            n++;
        end
        n_cmp++;
        if (od[0] !== v) begin
            n_bad++;
            $display("FAIL bp_capture got %h want %h", od[0], v);
        end
        dsv[0] = ~v;
        iv[0] = 1'b1;
        idat[0] = 8'h33;
        for (int i = 0; i < 5; i++) begin
            tick;
            n_cmp++;
            if ({ov[0], ir[0]} !== 2'b10 || od[0] !== v) begin
                n_bad++;
                $display("FAIL bp_hold c=%0d got v%0b r%0b %h want v1 r0 %h",
                         i, ov[0], ir[0], od[0], v);
            end
        end
        ordy[0] = 1'b1;
        iv[0] = 1'b0;
        tick;
        n_cmp++;
        if ({ir[0], ov[0], la[0]} !== 10'b10_0000_0000) begin
            n_bad++;
            $display("FAIL bp_release got r%0b v%0b want r1 v0", ir[0], ov[0]);
        end
        tick;
        n_cmp++;
        if (ir[0] !== 1'b1) begin
            n_bad++;
            $display("FAIL bp_ignored got ready %0b want 1", ir[0]);
        end
    endtask

    task automatic test_reset_mid;
        bit ok;
        logic [15:0] got;
        ordy[0] = 1'b1;
        wait_ready(0, ok);
        iv[0] = 1'b1;
        idat[0] = 8'hFF;
        tick;
        iv[0] = 1'b0;
        repeat (3) tick;
        n_cmp++;
        if ({ae[0], bi[0]} !== 4'b1011) begin
            n_bad++;
            $display("FAIL mid_k3 got en%0b k%0d want en1 k3", ae[0], bi[0]);
        end
        rst_n = 1'b0;
        #1;
        got = {ir[0], ov[0], la[0], bi[0], ac[0], ae[0], asb[0]};
        n_cmp++;
        if (got !== {1'b1, 15'd0} || od[0] !== '0) begin
            n_bad++;
            $display("FAIL mid_reset got %h/%h want 8000/0", got, od[0]);
        end
        tick;
        rst_n = 1'b1;
        tick;
        wait_ready(0, ok);
        iv[0] = 1'b1;
        idat[0] = 8'h01;
        tick;
        iv[0] = 1'b0;
        n_cmp++;
        if (la[0] !== 8'h01) begin
            n_bad++;
            $display("FAIL mid_cleared got %h want 01", la[0]);
        end
        wait_ready(0, ok);
    endtask

    task automatic test_capture(input int i);
        int L;
        int c;
        int nae;
        bit ok;
        logic [31:0] r;
        L = lat_of(i);
        ordy[i] = 1'b1;
        wait_ready(i, ok);
        n_cmp++;
        if (ok !== 1'b1) begin
            n_bad++;
            $display("FAIL cap_ready[%0d] got 0 want 1", i);
        end
        iv[i] = 1'b1;
        idat[i] = 8'($urandom);
        r = $urandom;
        dsv[i] = (r == 32'hDEAD_BEEF) ? 32'h0 : r;
        tick;
        iv[i] = 1'b0;
        c = 1;
        nae = 0;
        while (ov[i] !== 1'b1 && c < 40) begin
            nae += int'(ae[i]);
            r = $urandom;
            if (r == 32'hDEAD_BEEF) r = 32'h0;
            dsv[i] = (c == DW + L) ? 32'hDEAD_BEEF : r;
            tick;
            c++;
        end
        n_cmp++;
        if (c !== DW + L + 1) begin
            n_bad++;
            $display("FAIL cap_latency[lat%0d] got %0d want %0d", L, c, DW + L + 1);
        end
        n_cmp++;
        if (od[i] !== 32'hDEAD_BEEF) begin
            n_bad++;
            $display("FAIL cap_data[lat%0d] got %h want deadbeef", L, od[i]);
        end
        n_cmp++;
        if (nae !== DW) begin
            n_bad++;
            $display("FAIL cap_acc_en[lat%0d] got %0d want %0d", L, nae, DW);
        end
        tick;
    endtask

    task automatic test_back_to_back;
        int cyc;
        int nacc;
        int nout;
        int last;
        int y;
        for (int t = 0; t < TAPS; t++) coef[t] = 8'($urandom);
        for (int j = 0; j < NS; j++) xs[j] = int'($urandom_range(0, 255)) - 128;
        rst_n = 1'b0;
        tick;
        rst_n = 1'b1;
        use_model = 1'b1;
        ordy[0] = 1'b1;
        cyc = 0;
        nacc = 0;
        nout = 0;
        last = -1;
        tick;
        while (nout < NS && cyc < 600) begin
            if (ov[0] === 1'b1) begin
                y = ref_y(nout);
                n_cmp++;
                if (od[0] !== 32'(y)) begin
                    n_bad++;
                    $display("FAIL stream_out n=%0d got %h want %h", nout, od[0], 32'(y));
                end
                nout++;
            end
            if (ir[0] === 1'b1 && nacc < NS) begin
                iv[0] = 1'b1;
                idat[0] = 8'(xs[nacc]);
                if (last >= 0) begin
                    n_cmp++;
                    if (cyc - last !== DW + 1 + 2) begin
                        n_bad++;
                        $display("FAIL stream_gap n=%0d got %0d want %0d",
                                 nacc, cyc - last, DW + 3);
                    end
                end
                last = cyc;
                nacc++;
            end else begin
                iv[0] = 1'b0;
            end
            tick;
            cyc++;
        end
        iv[0] = 1'b0;
        use_model = 1'b0;
        n_cmp++;
        if (nout !== NS) begin
            n_bad++;
            $display("FAIL stream_count got %0d want %0d", nout, NS);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        use_model = 1'b0;
        for (int i = 0; i < NI; i++) begin
            iv[i] = 1'b0;
            idat[i] = '0;
            ordy[i] = 1'b1;
            dsv[i] = '0;
        end
        for (int t = 0; t < TAPS; t++) coef[t] = '0;
        test_reset;
        test_single;
        test_delay_line;
        test_backpressure;
        test_reset_mid;
        for (int i = 0; i < NI; i++) test_capture(i);
        test_back_to_back;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
